// File: rtl/nios_cpu_control_master.sv
// Avalon-MM initiator driving the control PIO (data/bit-set/bit-clear) for a non-CPU client.
// One command in flight; keeps a shadow of the PIO out_port and returns read data or the new shadow.
module nios_cpu_control_master #(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic [DATA_W-1:0] shadow_out,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_SET, OP_CLEAR} op_t;

    // Timeout fires on the TIMEOUT-th stalled ISSUE cycle.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]  RD_LAT    = 3'(READ_LATENCY);

    state_t            state;
    op_t               op_q;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       wait_cnt;
    logic [2:0]        rd_cnt;
    logic [DATA_W-1:0] shadow_next;

    function automatic logic [2:0] addr_of(op_t op);
        case (op)
            OP_SET:   return 3'd4;
            OP_CLEAR: return 3'd5;
            default:  return 3'd0;
        endcase
    endfunction

    always_comb begin
        shadow_next = shadow_out;
        case (op_q)
            OP_WRITE: shadow_next = data_q;
            OP_SET:   shadow_next = shadow_out | data_q;
            OP_CLEAR: shadow_next = shadow_out & ~data_q;
            default:  shadow_next = shadow_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op_q           <= OP_WRITE;
            data_q         <= '0;
            wait_cnt       <= '0;
            rd_cnt         <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
            shadow_out     <= '0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q           <= op_t'(cmd_op);
                        data_q         <= cmd_data;
                        cmd_ready      <= 1'b0;
                        wait_cnt       <= '0;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= (op_t'(cmd_op) == OP_READ);
                        avm_address    <= addr_of(op_t'(cmd_op));
                        avm_writedata  <= cmd_data;
                        state          <= ISSUE;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!avm_waitrequest) begin
                        avm_chipselect <= 1'b0;
                        avm_write_n    <= 1'b1;
                        if (op_q == OP_READ) begin
                            rd_cnt <= RD_LAT;
                            state  <= RDWAIT;
                        end else begin
                            shadow_out <= shadow_next;
                            rsp_data   <= shadow_next;
                            rsp_error  <= 1'b0;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end
                    end else if (wait_cnt >= WAIT_LAST) begin
                        avm_chipselect <= 1'b0;
                        avm_write_n    <= 1'b1;
                        rsp_data       <= '0;
                        rsp_error      <= 1'b1;
                        rsp_valid      <= 1'b1;
                        state          <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RDWAIT: begin
                    // Slave readdata is valid READ_LATENCY cycles after the accepted read.
                    if (rd_cnt <= 3'd1) begin
                        rsp_data  <= avm_readdata;
                        rsp_error <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        rd_cnt <= rd_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_error <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
